dma_hold_master: RTL and testbench

- Memory-to-memory copy engine that takes ownership of the data-memory port through the CPU's hold/holdACK handshake.
- Requests the bus with `hold`, waits for `holdACK` from the main decoder, copies a block of words from one dmem region to another, then releases the bus.
- Sits beside the CPU core and shares the dmem address, data and write-enable path through the top-level bus mux, which selects the DMA side while `holdACK` is high.

---
 rtl/dma_hold_master_pkg.sv | 17 +
 rtl/dma_hold_master.sv | 152 +++++++++++++++
 tb/tb_dma_hold_master.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/dma_hold_master_pkg.sv
// Shared definitions for the hold/holdACK memory-to-memory copy engine.
package dma_hold_master_pkg;

    // Default dmem word-address width (64 words).
    localparam int DEFAULT_AW = 6;

    // Controller states, 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_READ    = 3'd2,
        ST_WRITE   = 3'd3,
        ST_RELEASE = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

endpackage

// File: rtl/dma_hold_master.sv
// Memory-to-memory copy engine that borrows the dmem port from the CPU
// through the hold/holdACK handshake, copying up to `burst` words per tenure.
module dma_hold_master
    import dma_hold_master_pkg::*;
#(
    parameter int wide  = 32,
    parameter int aw    = DEFAULT_AW,
    parameter int burst = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [aw-1:0]   src_addr,
    input  logic [aw-1:0]   dst_addr,
    input  logic [aw:0]     len,
    output logic            hold,
    input  logic            holdACK,
    output logic [aw-1:0]   dm_a,
    output logic [wide-1:0] dm_d,
    output logic            dm_we,
    input  logic [wide-1:0] dm_q,
    output logic            busy,
    output logic            done,
    output logic            err
);

    // Burst counter only needs to reach `burst`.
    localparam int CW = $clog2(burst + 1);
    localparam logic [CW-1:0] BURST_LIM = CW'(burst);
    localparam logic [aw:0]   LAST_WORD = (aw + 1)'(1);

    state_t         state;
    state_t         state_next;
    logic [aw-1:0]  src_ptr;
    logic [aw-1:0]  dst_ptr;
    logic [aw:0]    remaining;
    logic [CW-1:0]  burst_cnt;
    logic [wide-1:0] word_buf;

    // State register; reset drops any in-flight transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath: pointers, word counters, read buffer and sticky abort flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            burst_cnt <= '0;
            word_buf  <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        err <= 1'b0;
                        if (len != '0) begin
                            src_ptr   <= src_addr;
                            dst_ptr   <= dst_addr;
                            remaining <= len;
                        end
                    end
                end
                ST_REQ: begin
                    if (holdACK) begin
                        burst_cnt <= '0;
                    end
                end
                ST_READ: begin
                    if (holdACK) begin
                        word_buf <= dm_q;
                    end else begin
                        err <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (holdACK) begin
                        src_ptr   <= src_ptr + aw'(1);
                        dst_ptr   <= dst_ptr + aw'(1);
                        remaining <= remaining - LAST_WORD;
                        burst_cnt <= burst_cnt + CW'(1);
                    end else begin
                        err <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state and bus outputs; bus lines sit at zero outside READ/WRITE.
    always_comb begin
        state_next = state;
        hold       = 1'b0;
        dm_a       = '0;
        dm_d       = '0;
        dm_we      = 1'b0;
        busy       = (state != ST_IDLE);
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = (len == '0) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                hold = 1'b1;
                if (holdACK) begin
                    state_next = ST_READ;
                end
            end
            ST_READ: begin
                hold = 1'b1;
                dm_a = src_ptr;
                state_next = holdACK ? ST_WRITE : ST_RELEASE;
            end
            ST_WRITE: begin
                hold  = 1'b1;
                dm_a  = dst_ptr;
                dm_d  = word_buf;
                dm_we = holdACK;
                if (!holdACK) begin
                    state_next = ST_RELEASE;
                end else if (remaining == LAST_WORD) begin
                    state_next = ST_RELEASE;
                end else if (burst_cnt + CW'(1) == BURST_LIM) begin
                    state_next = ST_RELEASE;
                end else begin
                    state_next = ST_READ;
                end
            end
            ST_RELEASE: begin
                state_next = (err || remaining == '0) ? ST_DONE : ST_REQ;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dma_hold_master.sv
// Self-checking bench for dma_hold_master: behavioural dmem and CPU grant,
// reference copy model computed from word counts and burst arithmetic.
module tb_dma_hold_master;

    localparam int BURST = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  src_addr;
    logic [5:0]  dst_addr;
    logic [6:0]  len;
    logic        hold;
    logic        holdACK;
    logic [5:0]  dm_a;
    logic [31:0] dm_d;
    logic        dm_we;
    logic [31:0] dm_q;
    logic        busy;
    logic        done;
    logic        err;

    // Bench environment state.
    logic [31:0] mem [64];
    logic        load_en;
    logic [5:0]  load_addr;
    logic [31:0] load_data;
    int          ack_mode;
    logic        ack_force_low;
    logic        ack_reg;
    int          done_cnt, rise_cnt, rel_cnt, wr_cnt;
    logic        prev_hold;
    int          n_checks = 0;
    int          n_fail = 0;

    dma_hold_master #(.wide(32), .aw(6), .burst(BURST)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .hold     (hold),
        .holdACK  (holdACK),
        .dm_a     (dm_a),
        .dm_d     (dm_d),
        .dm_we    (dm_we),
        .dm_q     (dm_q),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    // CPU grant: mode 0 grants immediately, mode 1 grants one cycle after hold.
    always @(posedge clk or negedge rst) begin
        if (!rst) ack_reg <= 1'b0;
        else      ack_reg <= hold;
    end
    assign holdACK = ack_force_low ? 1'b0 : ((ack_mode == 1) ? ack_reg : 1'b1);

    // Data memory with combinational read and a bench back-door load port.
    always @(posedge clk) begin
        if (load_en)    mem[load_addr] <= load_data;
        else if (dm_we) mem[dm_a] <= dm_d;
    end
    assign dm_q = mem[dm_a];

    // Activity counters sampled mid-cycle.
    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            done_cnt  <= 0;
            rise_cnt  <= 0;
            rel_cnt   <= 0;
            wr_cnt    <= 0;
            prev_hold <= 1'b0;
        end else begin
            if (done) done_cnt <= done_cnt + 1;
            if (hold && !prev_hold) rise_cnt <= rise_cnt + 1;
            if (busy && !hold && !done) rel_cnt <= rel_cnt + 1;
            if (dm_we) wr_cnt <= wr_cnt + 1;
            prev_hold <= hold;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    task automatic loadMem;
        for (int i = 0; i < 64; i++) begin
            load_en   = 1'b1;
            load_addr = 6'(i);
            load_data = $urandom;
            tick();
        end
        load_en = 1'b0;
    endtask

    // Reference latency from start cycle to done: each tenure is optional
    // grant wait, REQ, 2 cycles per word and a RELEASE; plus the DONE cycle.
    function automatic int expLatency(input int n, input int mode);
        int t;
        if (n == 0) return 1;
        t = (n + BURST - 1) / BURST;
        return (mode == 1) ? (2 * n + 3 * t + 1) : (2 * n + 2 * t + 1);
    endfunction

    // One transfer: run it, then compare memory, timing and activity with the model.
    task automatic applyStimulus(input string tag, input int s, input int d, input int n,
                                 input int mode, input bit poke, input int revoke_cyc,
                                 input int exp_words, input bit exp_err, input int exp_lat);
        logic [31:0] ref_mem [64];
        int lat, d_done, d_rise, d_rel, d_wr, bad, tenures;
        for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
        for (int i = 0; i < exp_words; i++) ref_mem[(d + i) % 64] = ref_mem[(s + i) % 64];
        tenures = (revoke_cyc != 0) ? 1 : (n + BURST - 1) / BURST;
        ack_mode = mode;
        d_done = done_cnt; d_rise = rise_cnt; d_rel = rel_cnt; d_wr = wr_cnt;
        src_addr = 6'(s);
        dst_addr = 6'(d);
        len      = 7'(n);
        start    = 1'b1;
        tick();
        start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 700 && lat < 0; c++) begin
            if (done === 1'b1) begin
                lat = c;
            end else begin
                start = poke && (c == 3);
                if (poke && c == 3) begin
                    src_addr = 6'($urandom);
                    dst_addr = 6'($urandom);
                    len      = 7'($urandom_range(1, 64));
                end
                ack_force_low = (c == revoke_cyc);
                tick();
            end
        end
        start = 1'b0;
        ack_force_low = 1'b0;
        checkOutput({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        checkOutput({tag, "_err"}, 64'(err), 64'(exp_err));
        tick();
        checkOutput({tag, "_idle_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_idle_hold"}, 64'(hold), 64'd0);
        tick();
        checkOutput({tag, "_err_sticky"}, 64'(err), 64'(exp_err));
        checkOutput({tag, "_done_pulses"}, 64'(done_cnt - d_done), 64'd1);
        checkOutput({tag, "_grants"}, 64'(rise_cnt - d_rise), 64'(tenures));
        checkOutput({tag, "_release_cycles"}, 64'(rel_cnt - d_rel), 64'(tenures));
        checkOutput({tag, "_writes"}, 64'(wr_cnt - d_wr), 64'(exp_words));
        bad = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) bad++;
        checkOutput({tag, "_mem_bad_words"}, 64'(bad), 64'd0);
    endtask

    initial begin
        logic [31:0] pre;
        int s, d, n, m;
        rst = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        ack_mode = 0; ack_force_low = 1'b0;
        tick(); tick();
        checkOutput("reset_hold", 64'(hold), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_err", 64'(err), 64'd0);
        checkOutput("reset_we", 64'(dm_we), 64'd0);
        checkOutput("reset_addr", 64'(dm_a), 64'd0);
        checkOutput("reset_data", 64'(dm_d), 64'd0);
        rst = 1'b1;
        tick();
        loadMem();

        applyStimulus("basic",  0, 16,  4, 1, 1'b0, 0,  4, 1'b0, expLatency(4, 1));
        applyStimulus("burst",  0, 32, 20, 1, 1'b0, 0, 20, 1'b0, expLatency(20, 1));
        applyStimulus("wrapsrc", 62, 30, 4, 0, 1'b0, 0, 4, 1'b0, expLatency(4, 0));
        applyStimulus("wrapdst", 10, 62, 3, 0, 1'b0, 0, 3, 1'b0, expLatency(3, 0));
        applyStimulus("len0",   5,  9,  0, 1, 1'b0, 0,  0, 1'b0, 1);
        applyStimulus("busystart", 5, 20, 10, 0, 1'b1, 0, 10, 1'b0, expLatency(10, 0));
        // Grant drops in the 3rd WRITE (cycle 7): two words land, then RELEASE, DONE.
        applyStimulus("revoke", 8, 48,  6, 0, 1'b0, 7,  2, 1'b1, 9);
        applyStimulus("clearerr", 1, 2, 0, 0, 1'b0, 0,  0, 1'b0, 1);

        for (int k = 0; k < 6; k++) begin
            s = int'($urandom_range(0, 63));
            d = int'($urandom_range(0, 63));
            n = int'($urandom_range(1, 64));
            m = int'($urandom_range(0, 1));
            applyStimulus($sformatf("rand%0d", k), s, d, n, m, 1'b0, 0, n, 1'b0, expLatency(n, m));
        end

        // Asynchronous reset while the first word is being written.
        ack_mode = 0;
        pre = mem[40];
        src_addr = 6'd0; dst_addr = 6'd40; len = 7'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        checkOutput("midreset_we_before", 64'(dm_we), 64'd1);
        #2 rst = 1'b0;
        #1;
        checkOutput("midreset_hold", 64'(hold), 64'd0);
        checkOutput("midreset_we", 64'(dm_we), 64'd0);
        checkOutput("midreset_busy", 64'(busy), 64'd0);
        tick();
        checkOutput("midreset_mem", 64'(mem[40]), 64'(pre));
        rst = 1'b1;
        tick();
        tick();
        checkOutput("midreset_stays_idle", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
